calc_engine: RTL and testbench

Keypad-driven calculator core. It consumes one-cycle keycode strobes from the keypad encoder and assembles decimal operands. It executes add/subtract/multiply with chaining and presents a 10-bit binary value to the bin2bcd/seven-segment display path, plus error and pending-operator status for the LEDs.

---
 rtl/calc_pkg.sv | 36 +++
 rtl/calc_alu.sv | 51 +++++
 rtl/calc_engine.sv | 181 ++++++++++++++++++
 tb/tb_calc_engine.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared keycodes, operator/state encodings and display limits for the keypad calculator.
package calc_pkg;

  localparam int WIDTH     = 10;
  localparam int MAX_VALUE = 999;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_MUL  = 4'hD;
  localparam logic [3:0] KEY_BKSP = 4'hE;
  localparam logic [3:0] KEY_EQ   = 4'hF;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    RESULT  = 2'd2,
    ERROR   = 2'd3
  } state_e;

  function automatic op_e key_to_op(input logic [3:0] k);
    case (k)
      KEY_ADD: key_to_op = OP_ADD;
      KEY_SUB: key_to_op = OP_SUB;
      default: key_to_op = OP_MUL;
    endcase
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational add/sub/mul on unsigned operands with range checking against the display limit.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH     = calc_pkg::WIDTH,
  parameter int MAX_VALUE = calc_pkg::MAX_VALUE
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [W2-1:0] MAX_W = W2'(MAX_VALUE);

  logic [W2-1:0] a_w;
  logic [W2-1:0] b_w;
  logic [W2-1:0] res_w;

  assign a_w = {{WIDTH{1'b0}}, a};
  assign b_w = {{WIDTH{1'b0}}, b};

  always_comb begin
    res_w    = b_w;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        res_w    = a_w + b_w;
        overflow = (res_w > MAX_W);
      end
      OP_SUB: begin
        // Negative results are not representable, so b > a is an error.
        res_w    = a_w - b_w;
        overflow = (b_w > a_w);
      end
      OP_MUL: begin
        res_w    = a_w * b_w;
        overflow = (res_w > MAX_W);
      end
      default: begin
        res_w    = b_w;
        overflow = 1'b0;
      end
    endcase
  end

  assign result = res_w[WIDTH-1:0];

endmodule

// File: rtl/calc_engine.sv
// Calculator core: operand entry, chained operators and registered display/status outputs.
// Handshake: key_valid is a one-cycle strobe with no backpressure; key_ack pulses one cycle after each accepted key.
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH     = calc_pkg::WIDTH,
  parameter int MAX_VALUE = calc_pkg::MAX_VALUE
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [3:0]       key_code,
  input  logic             key_valid,
  output logic [WIDTH-1:0] display_value,
  output logic             error,
  output logic [1:0]       op_pending,
  output logic             key_ack,
  output state_e           dbg_state
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [W2-1:0] MAX_W = W2'(MAX_VALUE);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic             started_q, started_d;
  logic             ack_q, ack_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] display_q, display_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;
  logic [W2-1:0]    entry_w;
  logic [W2-1:0]    append_w;
  logic [WIDTH-1:0] shrink;
  logic             is_digit;
  logic             is_op;

  // One ALU serves both chaining and equals: both compute acc op entry.
  calc_alu #(.WIDTH(WIDTH), .MAX_VALUE(MAX_VALUE)) u_alu (
    .a        (acc_q),
    .b        (entry_q),
    .op       (op_q),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  assign entry_w  = {{WIDTH{1'b0}}, entry_q};
  assign append_w = (entry_w << 3) + (entry_w << 1) + {{(W2-4){1'b0}}, key_code};
  assign shrink   = entry_q / WIDTH'(10);
  assign is_digit = (key_code <= 4'd9);
  assign is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB) || (key_code == KEY_MUL);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    entry_d   = entry_q;
    started_d = started_q;
    ack_d     = 1'b0;
    if (key_valid) begin
      if (key_code == KEY_CLR) begin
        state_d   = ENTRY_A;
        op_d      = OP_NONE;
        acc_d     = '0;
        entry_d   = '0;
        started_d = 1'b0;
        ack_d     = 1'b1;
      end else begin
        case (state_q)
          ENTRY_A, ENTRY_B: begin
            if (is_digit) begin
              if (append_w <= MAX_W) begin
                entry_d   = append_w[WIDTH-1:0];
                started_d = 1'b1;
                ack_d     = 1'b1;
              end
            end else if (is_op) begin
              ack_d = 1'b1;
              if (state_q == ENTRY_A) begin
                acc_d     = entry_q;
                entry_d   = '0;
                started_d = 1'b0;
                op_d      = key_to_op(key_code);
                state_d   = ENTRY_B;
              end else if (!started_q) begin
                op_d = key_to_op(key_code);
              end else if (alu_overflow) begin
                state_d = ERROR;
              end else begin
                acc_d     = alu_result;
                entry_d   = '0;
                started_d = 1'b0;
                op_d      = key_to_op(key_code);
              end
            end else if (key_code == KEY_EQ) begin
              ack_d = 1'b1;
              if (state_q == ENTRY_A) begin
                acc_d   = entry_q;
                state_d = RESULT;
              end else if (!started_q) begin
                op_d    = OP_NONE;
                state_d = RESULT;
              end else if (alu_overflow) begin
                state_d = ERROR;
              end else begin
                acc_d   = alu_result;
                op_d    = OP_NONE;
                state_d = RESULT;
              end
            end else begin
              entry_d = shrink;
              if (shrink == '0) started_d = 1'b0;
              ack_d = 1'b1;
            end
          end
          RESULT: begin
            if (is_digit) begin
              entry_d   = WIDTH'(key_code);
              started_d = 1'b1;
              acc_d     = '0;
              state_d   = ENTRY_A;
              ack_d     = 1'b1;
            end else if (is_op) begin
              // Start a fresh second operand so a stale entry is never chained.
              op_d      = key_to_op(key_code);
              entry_d   = '0;
              started_d = 1'b0;
              state_d   = ENTRY_B;
              ack_d     = 1'b1;
            end else if (key_code == KEY_EQ) begin
              ack_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    display_d = '0;
    case (state_d)
      ENTRY_A: display_d = entry_d;
      ENTRY_B: display_d = started_d ? entry_d : acc_d;
      RESULT:  display_d = acc_d;
      default: display_d = '0;
    endcase
    error_d = (state_d == ERROR);
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q   <= ENTRY_A;
      op_q      <= OP_NONE;
      acc_q     <= '0;
      entry_q   <= '0;
      started_q <= 1'b0;
      ack_q     <= 1'b0;
      error_q   <= 1'b0;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      entry_q   <= entry_d;
      started_q <= started_d;
      ack_q     <= ack_d;
      error_q   <= error_d;
      display_q <= display_d;
    end
  end

  assign display_value = display_q;
  assign error         = error_q;
  assign op_pending    = op_q;
  assign key_ack       = ack_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed-vector bench for calc_engine with hand-computed display, status and ack expectations.
module tb_calc_engine;
  import calc_pkg::*;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_valid = 1'b0;
  logic [9:0] display_value;
  logic       error;
  logic [1:0] op_pending;
  logic       key_ack;
  state_e     dbg_state;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];

  calc_engine dut (
    .Clk           (Clk),
    .reset         (reset),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .display_value (display_value),
    .error         (error),
    .op_pending    (op_pending),
    .key_ack       (key_ack),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drivers: inputs change #1 after the edge, outputs sampled at that same point
  task automatic idle();
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(0, 15));
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(posedge Clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(0, 15));
  endtask

  // scoreboard: queue the expected display, press, then pop and compare
  task automatic step(input string tag, input logic [3:0] k, input int exp_disp, input int exp_ack);
    exp_q.push_back(10'(exp_disp));
    press(k);
    check_eq({tag, "_disp"}, int'(display_value), int'(exp_q.pop_front()));
    check_eq({tag, "_ack"}, int'(key_ack), exp_ack);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_disp", int'(display_value), 0);
    check_eq("rst_err", int'(error), 0);
    check_eq("rst_op", int'(op_pending), 0);
    check_eq("rst_ack", int'(key_ack), 0);
    check_eq("rst_state", int'(dbg_state), int'(ENTRY_A));
    reset = 1'b1;
    idle();

    step("t1_k1", 4'd1, 1, 1);
    step("t1_k2", 4'd2, 12, 1);
    step("t1_k3", 4'd3, 123, 1);
    check_eq("t1_op", int'(op_pending), 0);
    idle();
    check_eq("t1_ack_low", int'(key_ack), 0);
    check_eq("t1_hold", int'(display_value), 123);

    step("t2_clr", KEY_CLR, 0, 1);
    step("t2_k1", 4'd1, 1, 1);
    step("t2_k2", 4'd2, 12, 1);
    step("t2_add", KEY_ADD, 12, 1);
    check_eq("t2_op_add", int'(op_pending), 1);
    step("t2_k3", 4'd3, 3, 1);
    step("t2_k0", 4'd0, 30, 1);
    step("t2_eq", KEY_EQ, 42, 1);
    check_eq("t2_op_none", int'(op_pending), 0);
    check_eq("t2_state", int'(dbg_state), int'(RESULT));

    step("t3_clr", KEY_CLR, 0, 1);
    step("t3_k5", 4'd5, 5, 1);
    step("t3_mul", KEY_MUL, 5, 1);
    check_eq("t3_op_mul", int'(op_pending), 3);
    step("t3_k6", 4'd6, 6, 1);
    step("t3_chain", KEY_ADD, 30, 1);
    check_eq("t3_op_add", int'(op_pending), 1);
    step("t3_k7", 4'd7, 7, 1);
    step("t3_eq", KEY_EQ, 37, 1);

    step("t4_clr", KEY_CLR, 0, 1);
    step("t4_k5", 4'd5, 5, 1);
    step("t4_k0a", 4'd0, 50, 1);
    step("t4_k0b", 4'd0, 500, 1);
    step("t4_add", KEY_ADD, 500, 1);
    step("t4_k6", 4'd6, 6, 1);
    step("t4_k0c", 4'd0, 60, 1);
    step("t4_k0d", 4'd0, 600, 1);
    step("t4_eq", KEY_EQ, 0, 1);
    check_eq("t4_err", int'(error), 1);
    step("t4_ign", 4'd4, 0, 0);
    check_eq("t4_err_hold", int'(error), 1);
    step("t4_clr2", KEY_CLR, 0, 1);
    check_eq("t4_err_clr", int'(error), 0);
    check_eq("t4_state", int'(dbg_state), int'(ENTRY_A));

    step("t5_k3", 4'd3, 3, 1);
    step("t5_sub", KEY_SUB, 3, 1);
    check_eq("t5_op_sub", int'(op_pending), 2);
    step("t5_k7", 4'd7, 7, 1);
    step("t5_eq", KEY_EQ, 0, 1);
    check_eq("t5_err", int'(error), 1);
    step("t5_clr", KEY_CLR, 0, 1);
    step("t5_k9a", 4'd9, 9, 1);
    step("t5_k9b", 4'd9, 99, 1);
    step("t5_k9c", 4'd9, 999, 1);
    step("t5_k9d", 4'd9, 999, 0);
    check_eq("t5_no_err", int'(error), 0);

    step("t6_clr", KEY_CLR, 0, 1);
    step("t6_k4", 4'd4, 4, 1);
    step("t6_k5", 4'd5, 45, 1);
    step("t6_bksp", KEY_BKSP, 4, 1);
    step("t6_k6", 4'd6, 46, 1);
    key_code  = KEY_ADD;
    key_valid = 1'b1;
    reset     = 1'b0;
    @(posedge Clk);
    #1;
    key_valid = 1'b0;
    reset     = 1'b1;
    check_eq("t6_rst_disp", int'(display_value), 0);
    check_eq("t6_rst_err", int'(error), 0);
    check_eq("t6_rst_op", int'(op_pending), 0);
    check_eq("t6_rst_ack", int'(key_ack), 0);
    check_eq("t6_rst_state", int'(dbg_state), int'(ENTRY_A));
    idle();
    check_eq("t6_drop_ack", int'(key_ack), 0);
    step("t6_k7", 4'd7, 7, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
